// File: rtl/ping_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ping_pkg
//  Purpose  : Shared types and defaults for the phase_ping transmit sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package ping_pkg;

  // System clock; blanking and holdoff defaults are derived from it.
  localparam int CLK_HZ          = 48_000_000;

  localparam int DEF_HPW         = 16;
  localparam int DEF_NCW         = 8;
  localparam int DEF_DEAD_CYC    = 4;
  localparam int DEF_BLANK_CYC   = CLK_HZ / 100_000;  // 10 us ring-down
  localparam int DEF_LISTEN_CYC  = 4096;
  localparam int DEF_HOLDOFF_CYC = CLK_HZ / 1_000;    // 1 ms re-trigger guard

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    BLANK   = 3'd2,
    LISTEN  = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  // Largest of three phase lengths; sizes the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ping_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : ping_seq_if
//  Purpose  : Control/config inputs and bridge/receiver outputs of ping_seq.
//  Revision : 1.0  initial release
// ============================================================================
interface ping_seq_if
  import ping_pkg::*;
#(
  parameter int HPW = DEF_HPW,
  parameter int NCW = DEF_NCW
) ();

  logic           trig;
  logic           abort;
  logic [HPW-1:0] half_per;
  logic [NCW-1:0] n_cyc;
  logic           drv_p;
  logic           drv_n;
  logic           blank;
  logic           arm;
  logic           busy;
  logic           err;

  // Requester side (host / testbench)
  modport master (
    output trig, abort, half_per, n_cyc,
    input  drv_p, drv_n, blank, arm, busy, err
  );

  // Sequencer side
  modport slave (
    input  trig, abort, half_per, n_cyc,
    output drv_p, drv_n, blank, arm, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/ping_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : ping_bridge
//  Purpose  : Registered complementary bridge legs with dead-time insertion.
//             Inputs are the next-cycle half parity / in-half count so the
//             registered legs line up with the sequencer's state register.
//  Revision : 1.0  initial release
// ============================================================================
module ping_bridge #(
  parameter int HPW      = 16,
  parameter int DEAD_CYC = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,    // asynchronous, active-low
  input  wire logic           en,
  input  wire logic           odd,
  input  wire logic [HPW-1:0] cnt,
  output logic                drv_p,
  output logic                drv_n
);

  logic drv_p_d, drv_p_q;
  logic drv_n_d, drv_n_q;
  logic live;

  // A leg may conduct only past the dead-time slot; parity picks the leg.
  always_comb begin
    live    = en && (cnt >= HPW'(DEAD_CYC));
    drv_p_d = live && !odd;
    drv_n_d = live &&  odd;
  end

  // Leg registers; reset drops both legs immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drv_p_q <= 1'b0;
      drv_n_q <= 1'b0;
    end else begin
      drv_p_q <= drv_p_d;
      drv_n_q <= drv_n_d;
    end
  end

  assign drv_p = drv_p_q;
  assign drv_n = drv_n_q;

  // Shoot-through guard: both legs high would short the bridge.
  a_leg_excl: assert property (@(posedge clk) disable iff (!rst) !(drv_p_q && drv_n_q));

endmodule
`default_nettype wire

// File: rtl/ping_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ping_seq
//  Purpose  : Burst / blank / arm / listen / holdoff transmit sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module ping_seq
  import ping_pkg::*;
#(
  parameter int DEAD_CYC    = DEF_DEAD_CYC,
  parameter int BLANK_CYC   = DEF_BLANK_CYC,
  parameter int LISTEN_CYC  = DEF_LISTEN_CYC,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
  parameter int HPW         = DEF_HPW,
  parameter int NCW         = DEF_NCW
) (
  input  wire logic   clk,
  input  wire logic   rst,    // asynchronous, active-low
  ping_seq_if.slave   bus
);

  localparam int TMAX = max3(BLANK_CYC, LISTEN_CYC, HOLDOFF_CYC);
  localparam int TW   = $clog2(TMAX + 1);

  state_t         state_q, state_d;
  logic [HPW-1:0] c_q, c_d;        // in-half counter
  logic [NCW:0]   h_q, h_d;        // half index
  logic [HPW-1:0] hp_q, hp_d;      // latched half-period
  logic [NCW-1:0] nc_q, nc_d;      // latched cycle count
  logic [TW-1:0]  t_q, t_d;        // BLANK/LISTEN/HOLDOFF timer
  logic           blank_q, blank_d;
  logic           arm_q, arm_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic [NCW:0]   h_last;
  logic           cfg_ok;
  logic           drv_p_w, drv_n_w;

  // Sequencer next state, counters and registered-output decode.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    h_d     = h_q;
    hp_d    = hp_q;
    nc_d    = nc_q;
    t_d     = t_q;
    err_d   = 1'b0;
    h_last  = {nc_q, 1'b0} - (NCW+1)'(1);
    cfg_ok  = (bus.half_per > HPW'(DEAD_CYC)) && (bus.n_cyc != '0);

    if (bus.abort) begin
      // Abort outranks everything, including a trigger in IDLE.
      state_d = IDLE;
      c_d     = '0;
      h_d     = '0;
      t_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.trig) begin
            if (cfg_ok) begin
              state_d = DRIVE;
              hp_d    = bus.half_per;
              nc_d    = bus.n_cyc;
              c_d     = '0;
              h_d     = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        DRIVE: begin
          if (c_q == hp_q - HPW'(1)) begin
            c_d = '0;
            if (h_q == h_last) begin
              state_d = BLANK;
              h_d     = '0;
              t_d     = '0;
            end else begin
              h_d = h_q + (NCW+1)'(1);
            end
          end else begin
            c_d = c_q + HPW'(1);
          end
        end
        BLANK: begin
          if (t_q == TW'(BLANK_CYC - 1)) begin
            state_d = LISTEN;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        LISTEN: begin
          if (t_q == TW'(LISTEN_CYC - 1)) begin
            state_d = HOLDOFF;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        HOLDOFF: begin
          if (t_q == TW'(HOLDOFF_CYC - 1)) begin
            state_d = IDLE;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register in step.
    blank_d = (state_d == DRIVE) || (state_d == BLANK);
    arm_d   = (state_d == LISTEN) && (state_q != LISTEN);
    busy_d  = (state_d != IDLE);
  end

  // State, counters, latched config and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      h_q     <= '0;
      hp_q    <= '0;
      nc_q    <= '0;
      t_q     <= '0;
      blank_q <= 1'b0;
      arm_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      h_q     <= h_d;
      hp_q    <= hp_d;
      nc_q    <= nc_d;
      t_q     <= t_d;
      blank_q <= blank_d;
      arm_q   <= arm_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  ping_bridge #(
    .HPW      (HPW),
    .DEAD_CYC (DEAD_CYC)
  ) u_bridge (
    .clk   (clk),
    .rst   (rst),
    .en    (state_d == DRIVE),
    .odd   (h_d[0]),
    .cnt   (c_d),
    .drv_p (drv_p_w),
    .drv_n (drv_n_w)
  );

  assign bus.drv_p = drv_p_w;
  assign bus.drv_n = drv_n_w;
  assign bus.blank = blank_q;
  assign bus.arm   = arm_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ping_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ping_seq
//  Purpose  : Self-checking bench for ping_seq with a cycle-index reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ping_seq;

  localparam int HPW  = 16;
  localparam int NCW  = 8;
  localparam int DEAD = 2;
  localparam int BLK  = 5;
  localparam int LIS  = 8;
  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst;

  ping_seq_if #(.HPW(HPW), .NCW(NCW)) bus ();

  ping_seq #(
    .DEAD_CYC    (DEAD),
    .BLANK_CYC   (BLK),
    .LISTEN_CYC  (LIS),
    .HOLDOFF_CYC (HOLD),
    .HPW         (HPW),
    .NCW         (NCW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference: a run is just "cycle k since acceptance" plus its config.
  bit m_act;
  bit m_err;
  int m_k, m_hp, m_n;

  logic [5:0] obs;
  assign obs = {bus.drv_p, bus.drv_n, bus.blank, bus.arm, bus.busy, bus.err};

  function automatic int run_len(input int hp, input int n);
    return 2 * n * hp + BLK + LIS + HOLD;
  endfunction

  // Expected {drv_p, drv_n, blank, arm, busy, err}.
  function automatic logic [5:0] model_out();
    int d, h, c;
    logic p, nn;
    if (!m_act) return {5'b0, m_err};
    d  = 2 * m_n * m_hp;
    p  = 1'b0;
    nn = 1'b0;
    if (m_k <= d) begin
      h = (m_k - 1) / m_hp;
      c = (m_k - 1) % m_hp;
      if (c >= DEAD) begin
        if (h % 2 == 0) p = 1'b1;
        else            nn = 1'b1;
      end
    end
    return {p, nn, (m_k <= d + BLK), (m_k == d + BLK + 1), 1'b1, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%b exp=%b (p,n,blank,arm,busy,err)", tag, cyc, got, exp);
    end
  endtask

  // Advance the reference by one clock edge given the sampled inputs.
  task automatic model_edge(input bit t, input bit a, input int hp, input int n);
    m_err = 1'b0;
    if (m_act) begin
      if (a) m_act = 1'b0;
      else begin
        m_k++;
        if (m_k > run_len(m_hp, m_n)) m_act = 1'b0;
      end
    end else if (t && !a) begin
      if (hp > DEAD && n != 0) begin
        m_act = 1'b1;
        m_k   = 1;
        m_hp  = hp;
        m_n   = n;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic tick(input bit t, input bit a, input int hp, input int n);
    @(negedge clk);
    bus.trig     = t;
    bus.abort    = a;
    bus.half_per = HPW'(hp);
    bus.n_cyc    = NCW'(n);
    @(posedge clk);
    model_edge(t, a, hp, n);
    cyc++;
    #1 chk("cyc", obs, model_out());
  endtask

  task automatic idle(input int cnt, input int hp, input int n);
    repeat (cnt) tick(1'b0, 1'b0, hp, n);
  endtask

  // Shoot-through watch over the whole run.
  always @(negedge clk) begin
    if (rst) begin
      n_tests++;
      assert (!(bus.drv_p && bus.drv_n)) else begin
        n_fail++;
        $error("FAIL excl cyc=%0d got=%b%b exp=not both high", cyc, bus.drv_p, bus.drv_n);
      end
    end
  end

  initial begin
    bit t, a;
    int hp, n;
    bus.trig     = 1'b0;
    bus.abort    = 1'b0;
    bus.half_per = '0;
    bus.n_cyc    = '0;
    m_act = 1'b0;
    m_err = 1'b0;
    m_k   = 0;
    m_hp  = 0;
    m_n   = 0;
    rst   = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset", obs, 6'b0);
    @(negedge clk) rst = 1'b1;
    idle(2, 6, 2);

    // Nominal burst: half_per=6, n_cyc=2 -> 40 busy cycles.
    tick(1'b1, 1'b0, 6, 2);
    idle(41, 6, 2);

    // Rejections, plus the smallest legal half-period.
    tick(1'b1, 1'b0, 2, 2);
    idle(3, 2, 2);
    tick(1'b1, 1'b0, 6, 0);
    idle(3, 6, 0);
    tick(1'b1, 1'b0, 3, 1);
    idle(24, 3, 1);

    // Retrigger at cycle 10 is ignored.
    tick(1'b1, 1'b0, 6, 2);
    idle(9, 6, 2);
    tick(1'b1, 1'b0, 7, 3);
    idle(31, 6, 2);

    // Config change after acceptance does not alter timing.
    tick(1'b1, 1'b0, 6, 2);
    idle(4, 6, 2);
    idle(37, 9, 2);

    // Abort at cycle 16 (drv_p high), fresh trig at cycle 18.
    tick(1'b1, 1'b0, 6, 2);
    idle(15, 6, 2);
    tick(1'b0, 1'b1, 6, 2);
    idle(1, 6, 2);
    tick(1'b1, 1'b0, 6, 1);
    idle(30, 6, 1);

    // Abort on the last BLANK cycle: no arm may follow.
    tick(1'b1, 1'b0, 4, 1);
    idle(12, 4, 1);
    tick(1'b0, 1'b1, 4, 1);
    idle(3, 4, 1);

    // Trig and abort together in IDLE: nothing starts, no err.
    tick(1'b1, 1'b1, 6, 2);
    idle(2, 6, 2);

    // Asynchronous reset while drv_n is high (cycle 22).
    tick(1'b1, 1'b0, 6, 2);
    idle(21, 6, 2);
    #2 rst = 1'b0;
    #1 chk("async_rst", obs, 6'b0);
    m_act = 1'b0;
    m_err = 1'b0;
    @(posedge clk);
    #1 chk("rst_hold", obs, 6'b0);
    @(negedge clk) rst = 1'b1;
    idle(3, 6, 2);

    // Randomized runs with sporadic triggers, aborts and config churn.
    for (int r = 0; r < 6; r++) begin
      hp = $urandom_range(0, 8);
      n  = $urandom_range(0, 3);
      for (int i = 0; i < 80; i++) begin
        t = (i == 0) || ($urandom_range(0, 15) == 0);
        a = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 9) == 0) hp = $urandom_range(0, 8);
        tick(t, a, hp, n);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
